// File: rtl/sram_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sram_arb_pkg
// Description : Shared constants and helpers for the SRAM port arbiter and
//               the round-robin arbiter it reuses.
// Revision    : 1.0 - initial release
// ============================================================================
package sram_arb_pkg;

  localparam int SRAM_AW   = 7;
  localparam int SRAM_DW   = 32;
  localparam int MAX_NPORT = 4;

  // Round-robin successor of a port index among n ports.
  function automatic int next_ptr(input int ptr, input int n);
    return (ptr + 1 >= n) ? 0 : ptr + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Purely combinational round-robin picker. Scans requests
//               starting at ptr and wrapping, returns one-hot grant and the
//               binary index of the winner.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
  parameter int N  = 2,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] winner
);

  logic          found;
  logic [IW-1:0] cand;

  // First active request at or after ptr (modulo N) wins.
  always_comb begin
    gnt    = '0;
    winner = '0;
    found  = 1'b0;
    cand   = '0;
    for (int k = 0; k < N; k++) begin
      cand = IW'((int'(ptr) + k) % N);
      if (!found && req[cand]) begin
        found     = 1'b1;
        gnt[cand] = 1'b1;
        winner    = cand;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/sram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : sram_port_arbiter
// Description : Shares one single-port SRAM among NPORT requesters with
//               round-robin arbitration, one access per cycle, and routes
//               1-cycle-latency read data back to the issuing port.
// Revision    : 1.0 - initial release
// ============================================================================
module sram_port_arbiter
  import sram_arb_pkg::*;
#(
  parameter int NPORT = 2,
  parameter int AW    = SRAM_AW,
  parameter int DW    = SRAM_DW
) (
  input  logic                CLK,
  input  logic                RESET_N,
  input  logic [NPORT-1:0]    req,
  input  logic [NPORT-1:0]    req_wr,
  input  logic [NPORT*AW-1:0] req_addr,
  input  logic [NPORT*DW-1:0] req_wdata,
  output logic [NPORT-1:0]    gnt,
  output logic [NPORT-1:0]    rvalid,
  output logic [DW-1:0]       rdata,
  output logic                sram_cen,
  output logic                sram_wen,
  output logic [AW-1:0]       sram_a,
  output logic [DW-1:0]       sram_d,
  input  logic [DW-1:0]       sram_q
);

  localparam int IW = (NPORT > 1) ? $clog2(NPORT) : 1;

  generate
    if (NPORT < 2 || NPORT > MAX_NPORT) begin : g_nport_check
      $error("sram_port_arbiter: NPORT must be in 2..%0d", MAX_NPORT);
    end
  endgenerate

  logic [NPORT-1:0] req_eff;
  logic [IW-1:0]    winner;
  logic             any_gnt;
  logic             win_wr;

  logic [IW-1:0]    ptr_q, ptr_d;
  logic             rd_pend_q, rd_pend_d;
  logic [IW-1:0]    rd_owner_q, rd_owner_d;

  // Holding reset masks every request so the SRAM sees no access.
  assign req_eff = req & {NPORT{RESET_N}};

  rr_arbiter #(
    .N  (NPORT),
    .IW (IW)
  ) u_rr (
    .req    (req_eff),
    .ptr    (ptr_q),
    .gnt    (gnt),
    .winner (winner)
  );

  assign any_gnt = |gnt;
  assign win_wr  = req_wr[winner];

  // Priority pointer and outstanding-read bookkeeping.
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      ptr_q      <= '0;
      rd_pend_q  <= 1'b0;
      rd_owner_q <= '0;
    end else begin
      ptr_q      <= ptr_d;
      rd_pend_q  <= rd_pend_d;
      rd_owner_q <= rd_owner_d;
    end
  end

  // Advance past the winner on a grant; a granted read owes data next cycle.
  always_comb begin
    ptr_d      = ptr_q;
    rd_pend_d  = 1'b0;
    rd_owner_d = rd_owner_q;
    if (any_gnt) begin
      ptr_d = IW'(next_ptr(int'(winner), NPORT));
      if (!win_wr) begin
        rd_pend_d  = 1'b1;
        rd_owner_d = winner;
      end
    end
  end

  // Drive the SRAM pins from the winning port; idle pins are parked at 1/1/0/0.
  always_comb begin
    sram_cen = ~any_gnt;
    sram_wen = 1'b1;
    sram_a   = '0;
    sram_d   = '0;
    if (any_gnt) begin
      sram_wen = ~win_wr;
      sram_a   = req_addr[int'(winner)*AW +: AW];
      sram_d   = req_wdata[int'(winner)*DW +: DW];
    end
  end

  // Return read data to the port that issued the read one cycle earlier.
  always_comb begin
    rvalid = '0;
    if (rd_pend_q && RESET_N) begin
      rvalid[rd_owner_q] = 1'b1;
    end
  end

  // Shared bus: Q is only meaningful when some rvalid bit is set.
  assign rdata = sram_q;

endmodule
`default_nettype wire

// File: tb/tb_sram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_sram_port_arbiter
// Description : Self-checking bench for sram_port_arbiter. Two instances
//               (2 and 4 ports) each drive a behavioural SRAM; a reference
//               model predicts grants, pin values and read responses.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sram_port_arbiter;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;
  logic RESET_N;

  // Per-instance request state: instance 0 has 2 ports, instance 1 has 4.
  logic        p_req [2][4];
  logic        p_wr  [2][4];
  logic [6:0]  p_addr[2][4];
  logic [31:0] p_wd  [2][4];

  logic [1:0]   req2, wr2, gnt2, rv2;
  logic [13:0]  addr2;
  logic [63:0]  wd2;
  logic [31:0]  rdata2, d2, q2;
  logic         cen2, wen2;
  logic [6:0]   a2;

  logic [3:0]   req4, wr4, gnt4, rv4;
  logic [27:0]  addr4;
  logic [127:0] wd4;
  logic [31:0]  rdata4, d4, q4;
  logic         cen4, wen4;
  logic [6:0]   a4;

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      req2[i]          = p_req[0][i];
      wr2[i]           = p_wr[0][i];
      addr2[i*7 +: 7]  = p_addr[0][i];
      wd2[i*32 +: 32]  = p_wd[0][i];
    end
    for (int i = 0; i < 4; i++) begin
      req4[i]          = p_req[1][i];
      wr4[i]           = p_wr[1][i];
      addr4[i*7 +: 7]  = p_addr[1][i];
      wd4[i*32 +: 32]  = p_wd[1][i];
    end
  end

  sram_port_arbiter #(.NPORT(2), .AW(7), .DW(32)) u_dut2 (
    .CLK(CLK), .RESET_N(RESET_N), .req(req2), .req_wr(wr2), .req_addr(addr2),
    .req_wdata(wd2), .gnt(gnt2), .rvalid(rv2), .rdata(rdata2), .sram_cen(cen2),
    .sram_wen(wen2), .sram_a(a2), .sram_d(d2), .sram_q(q2)
  );

  sram_port_arbiter #(.NPORT(4), .AW(7), .DW(32)) u_dut4 (
    .CLK(CLK), .RESET_N(RESET_N), .req(req4), .req_wr(wr4), .req_addr(addr4),
    .req_wdata(wd4), .gnt(gnt4), .rvalid(rv4), .rdata(rdata4), .sram_cen(cen4),
    .sram_wen(wen4), .sram_a(a4), .sram_d(d4), .sram_q(q4)
  );

  // Behavioural single-port synchronous SRAMs.
  logic [31:0] mem2 [128];
  logic [31:0] mem4 [128];
  always @(posedge CLK) begin
    if (!cen2) begin
      if (!wen2) mem2[a2] <= d2;
      else       q2 <= mem2[a2];
    end
  end
  always @(posedge CLK) begin
    if (!cen4) begin
      if (!wen4) mem4[a4] <= d4;
      else       q4 <= mem4[a4];
    end
  end

  // Reference model state.
  int          n_assert = 0;
  int          n_fail   = 0;
  int          np  [2] = '{2, 4};
  int          m_ptr  [2];
  bit          m_pend [2];
  int          m_owner[2];
  logic [31:0] m_rexp [2];
  int          m_win  [2];
  logic [31:0] m_mem  [2][128];
  bit          keep = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic get_obs(input int k, output logic [3:0] og, output logic [3:0] orv,
                         output logic [31:0] ord, output logic ocen, output logic owen,
                         output logic [6:0] oa, output logic [31:0] od);
    if (k == 0) begin
      og = {2'b00, gnt2}; orv = {2'b00, rv2}; ord = rdata2;
      ocen = cen2; owen = wen2; oa = a2; od = d2;
    end else begin
      og = gnt4; orv = rv4; ord = rdata4;
      ocen = cen4; owen = wen4; oa = a4; od = d4;
    end
  endtask

  // Mid-cycle: predict and compare every output, then advance the model.
  task automatic tick_chk();
    int          n, w, p;
    logic [3:0]  eg, erv, og, orv;
    logic [31:0] ord, od;
    logic        ocen, owen;
    logic [6:0]  oa;
    @(negedge CLK);
    for (int k = 0; k < 2; k++) begin
      n = np[k];
      w = -1;
      eg = '0;
      erv = '0;
      if (RESET_N) begin
        for (int j = 0; j < n; j++) begin
          p = (m_ptr[k] + j) % n;
          if (w < 0 && p_req[k][p]) w = p;
        end
      end
      if (w >= 0) eg[w] = 1'b1;
      if (m_pend[k] && RESET_N) erv[m_owner[k]] = 1'b1;
      get_obs(k, og, orv, ord, ocen, owen, oa, od);
      chk($sformatf("gnt%0d", k),    32'(og),   32'(eg));
      chk($sformatf("cen%0d", k),    32'(ocen), 32'(w < 0));
      chk($sformatf("wen%0d", k),    32'(owen), (w >= 0) ? 32'(!p_wr[k][w]) : 32'd1);
      chk($sformatf("addr%0d", k),   32'(oa),   (w >= 0) ? 32'(p_addr[k][w]) : 32'd0);
      chk($sformatf("wdata%0d", k),  od,        (w >= 0) ? p_wd[k][w] : 32'd0);
      chk($sformatf("rvalid%0d", k), 32'(orv),  32'(erv));
      if (erv != 4'd0) chk($sformatf("rdata%0d", k), ord, m_rexp[k]);
      m_win[k] = w;
      if (!RESET_N) begin
        m_ptr[k] = 0; m_pend[k] = 1'b0; m_owner[k] = 0;
      end else begin
        m_pend[k] = 1'b0;
        if (w >= 0) begin
          m_ptr[k] = (w + 1) % n;
          if (p_wr[k][w]) m_mem[k][p_addr[k][w]] = p_wd[k][w];
          else begin
            m_pend[k]  = 1'b1;
            m_owner[k] = w;
            m_rexp[k]  = m_mem[k][p_addr[k][w]];
          end
        end
      end
    end
  endtask

  // Cross the active edge; a granted request is consumed unless held.
  task automatic adv();
    @(posedge CLK);
    #1;
    for (int k = 0; k < 2; k++)
      if (!keep && m_win[k] >= 0) p_req[k][m_win[k]] = 1'b0;
  endtask

  task automatic step();
    tick_chk();
    adv();
  endtask

  task automatic rq(input int k, input int p, input logic wr, input logic [6:0] a,
                    input logic [31:0] d);
    p_req[k][p] = 1'b1; p_wr[k][p] = wr; p_addr[k][p] = a; p_wd[k][p] = d;
  endtask

  initial begin
    int cnt[4];
    int last[4];
    int maxgap;
    bit busy;
    RESET_N = 1'b0;
    for (int k = 0; k < 2; k++) begin
      m_ptr[k] = 0; m_pend[k] = 1'b0; m_owner[k] = 0; m_win[k] = -1; m_rexp[k] = '0;
      for (int p = 0; p < 4; p++) begin
        p_req[k][p] = 1'b0; p_wr[k][p] = 1'b0; p_addr[k][p] = '0; p_wd[k][p] = '0;
      end
    end
    // Reset: no grants, SRAM idle, no responses.
    for (int i = 0; i < 3; i++) step();
    RESET_N = 1'b1;

    // Seed the words used by the directed checks.
    rq(0, 0, 1'b1, 7'd5, 32'hDEADBEEF); step();
    rq(0, 0, 1'b1, 7'd1, 32'h11111111); step();
    rq(0, 1, 1'b1, 7'd2, 32'h22222222); step();
    rq(0, 0, 1'b1, 7'd9, 32'h0000000A); step();

    // T1: single read by port 1.
    rq(0, 1, 1'b0, 7'd5, 32'h0);
    tick_chk(); chk("t1_gnt", 32'(gnt2), 32'h2); adv();
    tick_chk(); chk("t1_rvalid", 32'(rv2), 32'h2); chk("t1_rdata", rdata2, 32'hDEADBEEF); adv();
    tick_chk(); chk("t1_rvalid_off", 32'(rv2), 32'h0); adv();

    // T3: write then read of the top address.
    rq(0, 0, 1'b1, 7'd127, 32'h12345678);
    tick_chk(); chk("t3_wen_wr", 32'(wen2), 32'h0); adv();
    rq(0, 1, 1'b0, 7'd127, 32'h0);
    tick_chk(); chk("t3_wen_rd", 32'(wen2), 32'h1); adv();
    tick_chk(); chk("t3_rdata", rdata2, 32'h12345678); chk("t3_wen_idle", 32'(wen2), 32'h1); adv();

    // T4: write lands in the same cycle as the older read's response.
    rq(0, 0, 1'b0, 7'd9, 32'h0); step();
    rq(0, 1, 1'b1, 7'd9, 32'h0000000B);
    tick_chk(); chk("t4_rvalid", 32'(rv2), 32'h1); chk("t4_rdata_old", rdata2, 32'h0000000A); adv();
    rq(0, 0, 1'b0, 7'd9, 32'h0); step();
    tick_chk(); chk("t4_rdata_new", rdata2, 32'h0000000B); adv();

    // T5: reset right after a read grant discards the response.
    rq(0, 0, 1'b0, 7'd1, 32'h0); step();
    RESET_N = 1'b0;
    tick_chk(); chk("t5_rvalid", 32'(rv2), 32'h0); chk("t5_cen", 32'(cen2), 32'h1); adv();
    tick_chk(); chk("t5_cen_hold", 32'(cen2), 32'h1); adv();
    RESET_N = 1'b1;

    // T2: continuous contention right after reset release.
    keep = 1'b1;
    rq(0, 0, 1'b0, 7'd1, 32'h0);
    rq(0, 1, 1'b0, 7'd2, 32'h0);
    tick_chk(); chk("t2_gnt0", 32'(gnt2), 32'h1); adv();
    tick_chk(); chk("t2_gnt1", 32'(gnt2), 32'h2); chk("t2_rv1", 32'(rv2), 32'h1); adv();
    tick_chk(); chk("t2_gnt2", 32'(gnt2), 32'h1); chk("t2_rv2", 32'(rv2), 32'h2); adv();
    tick_chk(); chk("t2_gnt3", 32'(gnt2), 32'h2); adv();
    keep = 1'b0;
    p_req[0][0] = 1'b0; p_req[0][1] = 1'b0;
    step();

    // Initialise a small address window on both instances.
    for (int a = 0; a < 8; a++) begin
      rq(0, 0, 1'b1, 7'(a), $urandom);
      rq(1, 0, 1'b1, 7'(a), $urandom);
      step();
    end

    // Randomised traffic; pending requests stay stable until granted.
    for (int c = 0; c < 300; c++) begin
      for (int k = 0; k < 2; k++)
        for (int p = 0; p < np[k]; p++)
          if (!p_req[k][p] && $urandom_range(0, 1) == 1)
            rq(k, p, 1'($urandom_range(0, 1)), 7'($urandom_range(0, 7)), $urandom);
      step();
    end
    for (int c = 0; c < 12; c++) step();
    busy = 1'b0;
    for (int k = 0; k < 2; k++)
      for (int p = 0; p < 4; p++) busy = busy | p_req[k][p];
    chk("drain", 32'(busy), 32'h0);

    // T6: all four ports request continuously for 40 cycles.
    keep = 1'b1;
    for (int p = 0; p < 4; p++) begin
      rq(1, p, 1'b0, 7'(p), 32'h0);
      cnt[p] = 0;
      last[p] = -1;
    end
    maxgap = 0;
    for (int c = 0; c < 40; c++) begin
      tick_chk();
      for (int p = 0; p < 4; p++) begin
        if (gnt4[p]) begin
          cnt[p]++;
          if (c - last[p] > maxgap) maxgap = c - last[p];
          last[p] = c;
        end
      end
      adv();
    end
    keep = 1'b0;
    for (int p = 0; p < 4; p++) p_req[1][p] = 1'b0;
    for (int p = 0; p < 4; p++) chk($sformatf("t6_count%0d", p), cnt[p], 32'd10);
    chk("t6_gap_ok", 32'(maxgap <= 4), 32'h1);
    step();
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
